// File: rtl/ram_pkg.sv
// Shared sizing for the ram8 / RAM64 / RAM512 family of register files.
package ram_pkg;

    localparam int WIDTH_DEFAULT  = 16;
    localparam int ADDR_W_DEFAULT = 3;

    // Number of words addressed by an address bus of the given width.
    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/ram8_register_word.sv
// One storage word: a per-bit hold/load mux feeding a D flip-flop with
// asynchronous clear.
module register_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;

    // Hold/load mux: recirculate the stored value unless this word is loaded.
    always_comb begin
        d = load ? in : q;
    end

    // Word flip-flops; clear is asynchronous so reset needs no clock.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and simulation matches the synthesized netlist.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    assign out = q;

endmodule

// File: rtl/ram8.sv
// Eight-word (2**ADDR_W) register file: one-hot write decode gated by load,
// an array of register_word instances, and a combinational read selector.
module ram8
    import ram_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);

    localparam int DEPTH = depth(ADDR_W);

    logic [DEPTH-1:0] hit;
    logic [WIDTH-1:0] words [DEPTH];

    // Write decoder: route load to exactly the addressed word (dmux8way).
    // NOTE: hit gets a full default before the indexed update; without it
    // the unaddressed bits would hold their value and infer latches.
    always_comb begin
        hit          = '0;
        hit[address] = load;
    end

    // Storage array. Every word has its own asynchronous clear, so the
    // whole file reads zero the moment reset_n falls.
    // NOTE: this array is built from flops, not a RAM macro, so resetting
    // every word is intended and cheap; a true SRAM could not be cleared.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        register_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .in      (in),
            .load    (hit[i]),
            .out     (words[i])
        );
    end

    // Read selector (mux8way): zero latency and no write-through, so a
    // same-address write becomes visible only after the edge.
    always_comb begin
        out = words[address];
    end

endmodule
